// File: rtl/rst_seq_gen_pkg.sv
// rst_seq_pkg: state encoding, default timing constants and sizing helper for rst_seq_gen.
package rst_seq_pkg;
    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        INIT,
        SOC_REL,
        RUN,
        CLUSTER_RST
    } rst_seq_state_e;

    localparam int SYNC_STAGES_DEF          = 2;
    localparam int LOCK_WAIT_CYCLES_DEF     = 16;
    localparam int SOC_HOLD_CYCLES_DEF      = 8;
    localparam int CLUSTER_DELAY_CYCLES_DEF = 4;
    localparam int CLUSTER_RST_CYCLES_DEF   = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction
endpackage

// File: rtl/rst_seq_gen_if.sv
// rst_seq_gen_if: lock/request inputs and staged reset outputs of the reset sequencer.
interface rst_seq_gen_if;
    logic clk_locked_i;
    logic cluster_rst_req_i;
    logic initn_sync_o;
    logic rstn_sync_o;
    logic rstn_cluster_o;
    logic rstn_cluster_sync_soc_o;
    logic rst_done_o;

    modport master (
        output clk_locked_i, cluster_rst_req_i,
        input  initn_sync_o, rstn_sync_o, rstn_cluster_o, rstn_cluster_sync_soc_o, rst_done_o
    );
    modport slave (
        input  clk_locked_i, cluster_rst_req_i,
        output initn_sync_o, rstn_sync_o, rstn_cluster_o, rstn_cluster_sync_soc_o, rst_done_o
    );
endinterface

// File: rtl/rst_seq_gen_sync_cell.sv
// rst_sync_cell: STAGES-deep flop chain with async clear to CLR_VAL and synchronous capture of d_i.
module rst_sync_cell #(
    parameter int   STAGES  = 2,
    parameter logic CLR_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= {STAGES{CLR_VAL}};
        else         sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: ordered init/SoC/cluster reset release after board reset and clock lock.
// Define RST_SEQ_LOCK_MON_EN to restart the sequence whenever lock is lost after WAIT_LOCK.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES          = SYNC_STAGES_DEF,
    parameter int LOCK_WAIT_CYCLES     = LOCK_WAIT_CYCLES_DEF,
    parameter int SOC_HOLD_CYCLES      = SOC_HOLD_CYCLES_DEF,
    parameter int CLUSTER_DELAY_CYCLES = CLUSTER_DELAY_CYCLES_DEF,
    parameter int CLUSTER_RST_CYCLES   = CLUSTER_RST_CYCLES_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    rst_seq_gen_if.slave bus
);
    localparam int CNT_W = $clog2(max4(LOCK_WAIT_CYCLES, SOC_HOLD_CYCLES,
                                       CLUSTER_DELAY_CYCLES, CLUSTER_RST_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOC_LAST  = CNT_W'(SOC_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLD_LAST  = CNT_W'(CLUSTER_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CRST_LAST = CNT_W'(CLUSTER_RST_CYCLES - 1);

    rst_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_sync_n, lock_s, lock_lost, req_rise, req_q;
    logic             initn_q, initn_d, rstn_q, rstn_d, cl_q, cl_d, cl_sync_q;

    rst_sync_cell #(.STAGES(SYNC_STAGES), .CLR_VAL(1'b0)) u_rst_sync (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(1'b1), .q_o(rst_sync_n)
    );
    rst_sync_cell #(.STAGES(SYNC_STAGES), .CLR_VAL(1'b0)) u_lock_sync (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(bus.clk_locked_i), .q_o(lock_s)
    );

`ifdef RST_SEQ_LOCK_MON_EN
    assign lock_lost = ~lock_s;
`else
    assign lock_lost = 1'b0;
`endif

    assign req_rise = bus.cluster_rst_req_i & ~req_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:       state_d = rst_sync_n ? WAIT_LOCK : RESET;
            WAIT_LOCK:   state_d = (lock_s && cnt_q == LOCK_LAST) ? INIT : WAIT_LOCK;
            INIT:        state_d = lock_lost ? WAIT_LOCK : (cnt_q == SOC_LAST) ? SOC_REL : INIT;
            SOC_REL:     state_d = lock_lost ? WAIT_LOCK : (cnt_q == CLD_LAST) ? RUN : SOC_REL;
            RUN:         state_d = lock_lost ? WAIT_LOCK : req_rise ? CLUSTER_RST : RUN;
            CLUSTER_RST: state_d = lock_lost ? WAIT_LOCK : (cnt_q == CRST_LAST) ? RUN : CLUSTER_RST;
            default:     state_d = RESET;
        endcase
        // counter restarts on every state entry; a lock gap restarts the lock count
        cnt_d   = (state_d != state_q || state_q inside {RESET, RUN} ||
                   (state_q == WAIT_LOCK && !lock_s)) ? '0 : cnt_q + CNT_W'(1);
        initn_d = state_d inside {INIT, SOC_REL, RUN, CLUSTER_RST};
        rstn_d  = state_d inside {SOC_REL, RUN, CLUSTER_RST};
        cl_d    = state_d == RUN;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RESET;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            initn_q   <= 1'b0;
            rstn_q    <= 1'b0;
            cl_q      <= 1'b0;
            cl_sync_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= bus.cluster_rst_req_i;
            initn_q   <= initn_d;
            rstn_q    <= rstn_d;
            cl_q      <= cl_d;
            cl_sync_q <= cl_q;
        end
    end

    assign bus.initn_sync_o            = initn_q;
    assign bus.rstn_sync_o             = rstn_q;
    assign bus.rstn_cluster_o          = cl_q;
    assign bus.rstn_cluster_sync_soc_o = cl_sync_q;
    assign bus.rst_done_o              = (state_q == RUN) && cl_sync_q;
endmodule
